// File: rtl/id_ex_operand_stage.sv
// ID/EX register in front of the ALU: operand bypass, shamt/immediate selection, bubble and hold control.
// Build option ID_EX_BYPASS_EN: when defined, f1/f2 bypass muxes are active and hazard_o is 0; otherwise hazard_o flags a pending match.
module id_ex_operand_stage #(
    parameter int          DW      = 32,
    parameter int          AW      = 5,
    parameter logic [5:0]  RST_FUN = 6'b000000
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs_addr_i,
    input  logic [AW-1:0] id_rt_addr_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [AW-1:0] id_dst_i,
    input  logic          id_regwrite_i,
    input  logic [4:0]    id_shamt_i,
    input  logic [15:0]   id_imm16_i,
    input  logic          id_alusrc1_i,
    input  logic          id_alusrc2_i,
    input  logic          id_extop_i,
    input  logic          id_luop_i,
    input  logic [5:0]    id_alufun_i,
    input  logic          id_sign_i,
    input  logic          f1_regwrite_i,
    input  logic [AW-1:0] f1_dst_i,
    input  logic [DW-1:0] f1_data_i,
    input  logic          f2_regwrite_i,
    input  logic [AW-1:0] f2_dst_i,
    input  logic [DW-1:0] f2_data_i,
    output logic [DW-1:0] ex_alu_a_o,
    output logic [DW-1:0] ex_alu_b_o,
    output logic [5:0]    ex_alufun_o,
    output logic          ex_sign_o,
    output logic [DW-1:0] ex_store_data_o,
    output logic [AW-1:0] ex_dst_o,
    output logic          ex_regwrite_o,
    output logic          ex_valid_o,
    output logic          hazard_o
);

    logic          rs_f1, rs_f2, rt_f1, rt_f2;
    logic [DW-1:0] rs_val, rt_val, imm_ext;
    logic [DW-1:0] alu_a_d, alu_b_d;

    logic [DW-1:0] alu_a_q, alu_b_q, store_q;
    logic [5:0]    alufun_q;
    logic          sign_q, regwrite_q, valid_q;
    logic [AW-1:0] dst_q;

    assign rs_f1 = (id_rs_addr_i != '0) && f1_regwrite_i && (f1_dst_i == id_rs_addr_i);
    assign rs_f2 = (id_rs_addr_i != '0) && f2_regwrite_i && (f2_dst_i == id_rs_addr_i);
    assign rt_f1 = (id_rt_addr_i != '0) && f1_regwrite_i && (f1_dst_i == id_rt_addr_i);
    assign rt_f2 = (id_rt_addr_i != '0) && f2_regwrite_i && (f2_dst_i == id_rt_addr_i);

`ifdef ID_EX_BYPASS_EN
    // f1 is the younger result, so it takes precedence over f2
    assign rs_val   = rs_f1 ? f1_data_i : (rs_f2 ? f2_data_i : id_rs_data_i);
    assign rt_val   = rt_f1 ? f1_data_i : (rt_f2 ? f2_data_i : id_rt_data_i);
    assign hazard_o = 1'b0;
`else
    logic unused_fwd_data;
    assign unused_fwd_data = ^{f1_data_i, f2_data_i};
    assign rs_val   = id_rs_data_i;
    assign rt_val   = id_rt_data_i;
    assign hazard_o = id_valid_i & (rs_f1 | rs_f2 | rt_f1 | rt_f2);
`endif

    always_comb begin
        imm_ext = {{(DW-16){1'b0}}, id_imm16_i};
        if (id_luop_i) begin
            imm_ext = {id_imm16_i, {(DW-16){1'b0}}};
        end else if (id_extop_i) begin
            imm_ext = {{(DW-16){id_imm16_i[15]}}, id_imm16_i};
        end
    end

    assign alu_a_d = id_alusrc1_i ? {{(DW-5){1'b0}}, id_shamt_i} : rs_val;
    assign alu_b_d = id_alusrc2_i ? imm_ext : rt_val;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            store_q    <= '0;
            alufun_q   <= RST_FUN;
            sign_q     <= 1'b0;
            dst_q      <= '0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            alufun_q   <= RST_FUN;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
        end else if (!stall_i) begin
            // data is loaded even for a bubble; only the control fields are forced
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            store_q    <= rt_val;
            sign_q     <= id_sign_i;
            dst_q      <= id_dst_i;
            alufun_q   <= id_valid_i ? id_alufun_i : RST_FUN;
            regwrite_q <= id_regwrite_i & id_valid_i;
            valid_q    <= id_valid_i;
        end
    end

    assign ex_alu_a_o      = alu_a_q;
    assign ex_alu_b_o      = alu_b_q;
    assign ex_store_data_o = store_q;
    assign ex_alufun_o     = alufun_q;
    assign ex_sign_o       = sign_q;
    assign ex_dst_o        = dst_q;
    assign ex_regwrite_o   = regwrite_q;
    assign ex_valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: a reference model pushes expected stage contents into a
// scoreboard queue before each edge; each test pops and compares after the edge, plus fixed-value checks.
module tb_id_ex_operand_stage;

    localparam logic [5:0] RST_FUN = 6'b000000;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_dst, id_shamt;
    logic [31:0] id_rs_data, id_rt_data;
    logic        id_regwrite, id_alusrc1, id_alusrc2, id_extop, id_luop, id_sign;
    logic [15:0] id_imm16;
    logic [5:0]  id_alufun;
    logic        f1_regwrite, f2_regwrite;
    logic [4:0]  f1_dst, f2_dst;
    logic [31:0] f1_data, f2_data;

    logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [5:0]  ex_alufun;
    logic        ex_sign, ex_regwrite, ex_valid, hazard;
    logic [4:0]  ex_dst;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [5:0]  fun;
        logic        sign;
        logic [4:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
    } obs_t;

    obs_t mdl;
    obs_t sb[$];
    obs_t exp_v, got_v;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.DW(32), .AW(5), .RST_FUN(RST_FUN)) dut (
        .clk_i(clk), .reset_i(reset), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
        .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr),
        .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
        .id_dst_i(id_dst), .id_regwrite_i(id_regwrite), .id_shamt_i(id_shamt), .id_imm16_i(id_imm16),
        .id_alusrc1_i(id_alusrc1), .id_alusrc2_i(id_alusrc2), .id_extop_i(id_extop), .id_luop_i(id_luop),
        .id_alufun_i(id_alufun), .id_sign_i(id_sign),
        .f1_regwrite_i(f1_regwrite), .f1_dst_i(f1_dst), .f1_data_i(f1_data),
        .f2_regwrite_i(f2_regwrite), .f2_dst_i(f2_dst), .f2_data_i(f2_data),
        .ex_alu_a_o(ex_alu_a), .ex_alu_b_o(ex_alu_b), .ex_alufun_o(ex_alufun), .ex_sign_o(ex_sign),
        .ex_store_data_o(ex_store_data), .ex_dst_o(ex_dst), .ex_regwrite_o(ex_regwrite),
        .ex_valid_o(ex_valid), .hazard_o(hazard)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic obs_t mask(input obs_t x);
        obs_t m;
        m = x;
        if (!m.valid) begin
            m.sign = 1'b0;
            m.dst  = '0;
            m.a    = '0;
            m.b    = '0;
            m.st   = '0;
        end
        return m;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.valid = ex_valid;
        o.rw    = ex_regwrite;
        o.fun   = ex_alufun;
        o.sign  = ex_sign;
        o.dst   = ex_dst;
        o.a     = ex_alu_a;
        o.b     = ex_alu_b;
        o.st    = ex_store_data;
        return mask(o);
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] adr, input logic [31:0] rf);
`ifdef ID_EX_BYPASS_EN
        if (adr != 5'd0 && f1_regwrite && f1_dst == adr) return f1_data;
        if (adr != 5'd0 && f2_regwrite && f2_dst == adr) return f2_data;
`endif
        return rf;
    endfunction

    function automatic logic [31:0] imm_model();
        if (id_luop)  return {id_imm16, 16'h0000};
        if (id_extop) return {{16{id_imm16[15]}}, id_imm16};
        return {16'h0000, id_imm16};
    endfunction

    // model the edge from the currently driven inputs, queue the expectation, then advance
    task automatic step();
        obs_t n;
        n = mdl;
        if (reset) begin
            n     = '0;
            n.fun = RST_FUN;
        end else if (flush) begin
            n.valid = 1'b0;
            n.rw    = 1'b0;
            n.fun   = RST_FUN;
        end else if (!stall) begin
            n.a     = id_alusrc1 ? {27'b0, id_shamt} : fwd(id_rs_addr, id_rs_data);
            n.b     = id_alusrc2 ? imm_model() : fwd(id_rt_addr, id_rt_data);
            n.st    = fwd(id_rt_addr, id_rt_data);
            n.fun   = id_valid ? id_alufun : RST_FUN;
            n.sign  = id_sign;
            n.dst   = id_dst;
            n.rw    = id_regwrite & id_valid;
            n.valid = id_valid;
        end
        mdl = n;
        sb.push_back(mask(n));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; stall = 0; flush = 0; id_valid = 1;
        id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
        id_dst = 0; id_regwrite = 0; id_shamt = 0; id_imm16 = 0;
        id_alusrc1 = 0; id_alusrc2 = 0; id_extop = 0; id_luop = 0;
        id_alufun = 0; id_sign = 0;
        f1_regwrite = 0; f1_dst = 0; f1_data = 0;
        f2_regwrite = 0; f2_dst = 0; f2_data = 0;
    endtask

    task automatic randomize_inputs();
        stall = 1'($urandom); flush = 1'($urandom); id_valid = 1'($urandom);
        id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
        id_rs_data = $urandom; id_rt_data = $urandom;
        id_dst = 5'($urandom); id_regwrite = 1'($urandom);
        id_shamt = 5'($urandom); id_imm16 = 16'($urandom);
        id_alusrc1 = 1'($urandom); id_alusrc2 = 1'($urandom);
        id_extop = 1'($urandom); id_luop = 1'($urandom);
        id_alufun = 6'($urandom); id_sign = 1'($urandom);
        f1_regwrite = 1'($urandom); f1_dst = 5'($urandom_range(0, 3)); f1_data = $urandom;
        f2_regwrite = 1'($urandom); f2_dst = 5'($urandom_range(0, 3)); f2_data = $urandom;
    endtask

    task automatic test_reset();
        clear_inputs();
        mdl = '0;
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            reset = 1;
            step();
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL reset_sb got=%h exp=%h", got_v, exp_v); end
            n_cmp++;
            if ({ex_valid, ex_regwrite, ex_alufun, ex_sign, ex_dst, ex_alu_a, ex_alu_b, ex_store_data} !== '0) begin
                n_err++;
                $display("FAIL reset_zero valid=%b rw=%b fun=%h a=%h b=%h st=%h, required all zero",
                         ex_valid, ex_regwrite, ex_alufun, ex_alu_a, ex_alu_b, ex_store_data);
            end
        end
        clear_inputs();
        id_alufun = 6'h21; id_regwrite = 1; id_dst = 5'd7; id_rs_data = 32'h1111_2222;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL release_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_alufun !== 6'h21 || ex_regwrite !== 1'b1 || ex_alu_a !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL release_first valid=%b fun=%h rw=%b a=%h, required 1/21/1/11112222",
                     ex_valid, ex_alufun, ex_regwrite, ex_alu_a);
        end
    endtask

    task automatic test_basic();
        clear_inputs();
        id_rs_addr = 3; id_rt_addr = 4; id_rs_data = 5; id_rt_data = 7; id_alufun = 6'b000000;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL basic_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
        if (ex_alu_a !== 32'd5 || ex_alu_b !== 32'd7 || ex_valid !== 1'b1 || ex_store_data !== 32'd7) begin
            n_err++;
            $display("FAIL basic_ops a=%h b=%h st=%h valid=%b, required 5/7/7/1", ex_alu_a, ex_alu_b, ex_store_data, ex_valid);
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        id_rs_addr = 8; id_rs_data = 32'h0BAD_F00D;
        f1_regwrite = 1; f1_dst = 8; f1_data = 32'hAAAA_0000;
        f2_regwrite = 1; f2_dst = 8; f2_data = 32'h1234_5678;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL bypass_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
`ifdef ID_EX_BYPASS_EN
        if (ex_alu_a !== 32'hAAAA_0000) begin n_err++; $display("FAIL bypass_f1_wins a=%h, required aaaa0000", ex_alu_a); end
`else
        if (ex_alu_a !== 32'h0BAD_F00D) begin n_err++; $display("FAIL nobypass_rf a=%h, required 0badf00d", ex_alu_a); end
`endif
        id_rs_addr = 0; f1_dst = 0; f2_dst = 0;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL bypass_r0_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
        if (ex_alu_a !== 32'h0BAD_F00D) begin n_err++; $display("FAIL bypass_r0 a=%h, required 0badf00d", ex_alu_a); end
        // f2-only match on rt, store data follows rt even with alusrc2 set
        id_rt_addr = 5; id_rt_data = 32'h5555_5555; id_alusrc2 = 1; id_imm16 = 16'h0001;
        f1_dst = 6; f2_dst = 5; f2_data = 32'hCAFE_0002;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL bypass_f2_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
`ifdef ID_EX_BYPASS_EN
        if (ex_store_data !== 32'hCAFE_0002 || ex_alu_b !== 32'h1) begin
            n_err++; $display("FAIL bypass_f2_store st=%h b=%h, required cafe0002/1", ex_store_data, ex_alu_b);
        end
`else
        if (ex_store_data !== 32'h5555_5555 || ex_alu_b !== 32'h1) begin
            n_err++; $display("FAIL nobypass_store st=%h b=%h, required 55555555/1", ex_store_data, ex_alu_b);
        end
`endif
    endtask

    task automatic test_imm();
        logic [31:0] req_b [3];
        logic        ext_tab [3];
        logic        lu_tab [3];
        req_b[0] = 32'hFFFF_8001; ext_tab[0] = 1; lu_tab[0] = 0;
        req_b[1] = 32'h0000_8001; ext_tab[1] = 0; lu_tab[1] = 0;
        req_b[2] = 32'h8001_0000; ext_tab[2] = 1; lu_tab[2] = 1;
        clear_inputs();
        id_imm16 = 16'h8001; id_alusrc2 = 1; id_rt_data = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            id_extop = ext_tab[i]; id_luop = lu_tab[i];
            step();
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL imm_sb[%0d] got=%h exp=%h", i, got_v, exp_v); end
            n_cmp++;
            if (ex_alu_b !== req_b[i]) begin n_err++; $display("FAIL imm[%0d] b=%h, required %h", i, ex_alu_b, req_b[i]); end
        end
        id_alusrc1 = 1; id_shamt = 5'd31; id_rs_data = 32'hFFFF_FFFF;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL shamt_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
        if (ex_alu_a !== 32'h0000_001F) begin n_err++; $display("FAIL shamt a=%h, required 0000001f", ex_alu_a); end
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_rs_data = 32'h0000_00A5; id_rt_data = 32'h0000_005A; id_alufun = 6'h13;
        id_regwrite = 1; id_dst = 5'd12; id_sign = 1;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL load_x_sb got=%h exp=%h", got_v, exp_v); end
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            stall = 1; flush = 0; reset = 0;
            step();
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL stall_sb[%0d] got=%h exp=%h", i, got_v, exp_v); end
            n_cmp++;
            if (ex_alu_a !== 32'hA5 || ex_alu_b !== 32'h5A || ex_alufun !== 6'h13 || ex_dst !== 5'd12 || ex_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold[%0d] a=%h b=%h fun=%h dst=%0d valid=%b, required a5/5a/13/12/1",
                         i, ex_alu_a, ex_alu_b, ex_alufun, ex_dst, ex_valid);
            end
        end
        stall = 1; flush = 1; id_valid = 1; id_regwrite = 1;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL flush_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_alufun !== RST_FUN) begin
            n_err++; $display("FAIL flush_bubble valid=%b rw=%b fun=%h, required 0/0/%h", ex_valid, ex_regwrite, ex_alufun, RST_FUN);
        end
        clear_inputs();
        id_valid = 0; id_regwrite = 1; id_alufun = 6'h3F;
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL invalid_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_alufun !== RST_FUN) begin
            n_err++; $display("FAIL invalid_bubble valid=%b rw=%b fun=%h", ex_valid, ex_regwrite, ex_alufun);
        end
    endtask

    task automatic test_hazard();
        clear_inputs();
        id_rt_addr = 9; id_rt_data = 32'h0000_0999;
        f2_regwrite = 1; f2_dst = 9; f2_data = 32'hDEAD_0009;
        #1;
        n_cmp++;
`ifdef ID_EX_BYPASS_EN
        if (hazard !== 1'b0) begin n_err++; $display("FAIL hazard_tied hazard=%b, required 0", hazard); end
`else
        if (hazard !== 1'b1) begin n_err++; $display("FAIL hazard_rt9 hazard=%b, required 1", hazard); end
`endif
        step();
        exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL hazard_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
`ifdef ID_EX_BYPASS_EN
        if (ex_alu_b !== 32'hDEAD_0009) begin n_err++; $display("FAIL hazard_b b=%h, required dead0009", ex_alu_b); end
`else
        if (ex_alu_b !== 32'h0000_0999) begin n_err++; $display("FAIL hazard_b b=%h, required 00000999", ex_alu_b); end
`endif
        id_rt_addr = 0; f2_dst = 0;
        #1;
        n_cmp++;
        if (hazard !== 1'b0) begin n_err++; $display("FAIL hazard_r0 hazard=%b, required 0", hazard); end
        id_rs_addr = 2; f1_regwrite = 1; f1_dst = 2; id_valid = 0;
        #1;
        n_cmp++;
        if (hazard !== 1'b0) begin n_err++; $display("FAIL hazard_invalid hazard=%b, required 0", hazard); end
        id_valid = 1;
        #1;
        n_cmp++;
`ifdef ID_EX_BYPASS_EN
        if (hazard !== 1'b0) begin n_err++; $display("FAIL hazard_rs_tied hazard=%b, required 0", hazard); end
`else
        if (hazard !== 1'b1) begin n_err++; $display("FAIL hazard_rs_f1 hazard=%b, required 1", hazard); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 15) == 0);
            step();
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL random_sb[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_imm();
        test_stall_flush();
        test_hazard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
